// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Purpose  : HI/LO multiply / restoring-divide sequencer with pipeline stall
// Revision : 1.0
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   srcA,
  input  logic [DATA_W-1:0]   srcB,
  input  logic                flush,
  output logic                stall_req,
  output logic                busy,
  output logic                hilo_we,
  output logic [2*DATA_W-1:0] hilo_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic                w_accept;

  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_sgn;
  logic                r_dz;
  logic                r_prep;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_negq;
  logic                r_negr;
  logic [2*DATA_W-1:0] r_res;
  logic [2*DATA_W-1:0] r_hilo;

  logic [2*DATA_W-1:0] w_ea;
  logic [2*DATA_W-1:0] w_eb;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_absa;
  logic [DATA_W-1:0]   w_absb;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_trial;
  logic [DATA_W-1:0]   w_rem_nx;
  logic [DATA_W-1:0]   w_quo_nx;
  logic [2*DATA_W-1:0] w_div_res;

  assign w_accept = (r_state == S_IDLE) && start && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush returns any active state to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = op[1] ? S_DIV : S_MUL;
      S_MUL:  w_next = S_DONE;
      S_DIV:  if (!r_prep && (r_cnt == C_LAST)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Outputs; the result is visible during DONE, committed to r_hilo at its end
  always_comb begin
    busy      = (r_state != S_IDLE);
    stall_req = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    hilo_we   = (r_state == S_DONE) && !flush;
    hilo_out  = hilo_we ? r_res : r_hilo;
  end

  assign w_ea   = r_sgn ? {{DATA_W{r_a[DATA_W-1]}}, r_a} : {{DATA_W{1'b0}}, r_a};
  assign w_eb   = r_sgn ? {{DATA_W{r_b[DATA_W-1]}}, r_b} : {{DATA_W{1'b0}}, r_b};
  assign w_prod = w_ea * w_eb;

  assign w_absa = (r_sgn && r_a[DATA_W-1]) ? (~r_a + 1'b1) : r_a;
  assign w_absb = (r_sgn && r_b[DATA_W-1]) ? (~r_b + 1'b1) : r_b;

  // One restoring step: shift the next dividend bit into the partial remainder
  assign w_shift  = {r_rem, r_quo[DATA_W-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  assign w_rem_nx = w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quo_nx = {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};

  assign w_div_res = r_dz ? {r_a, {DATA_W{1'b1}}}
                          : {(r_negr ? (~w_rem_nx + 1'b1) : w_rem_nx),
                             (r_negq ? (~w_quo_nx + 1'b1) : w_quo_nx)};

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sgn  <= 1'b0;
      r_dz   <= 1'b0;
      r_prep <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_res  <= '0;
      r_hilo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= srcA;
            r_b    <= srcB;
            r_sgn  <= ~op[0];
            r_dz   <= (srcB == '0);
            r_prep <= 1'b1;
            r_cnt  <= '0;
          end
        end
        S_MUL: r_res <= w_prod;
        S_DIV: begin
          if (r_prep) begin
            // First DIV cycle only prepares magnitudes and fixup signs
            r_quo  <= w_absa;
            r_dvs  <= w_absb;
            r_rem  <= '0;
            r_negq <= r_sgn && (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
            r_negr <= r_sgn && r_a[DATA_W-1];
            r_prep <= 1'b0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) r_res <= w_div_res;
          end
        end
        S_DONE: if (!flush) r_hilo <= r_res;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_ctrl
// Purpose  : Scoreboard bench for hilo_muldiv_ctrl
// Revision : 1.0
// ============================================================================
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_out;

  hilo_muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .stall_req(stall_req), .busy(busy), .hilo_we(hilo_we),
    .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS HI/LO semantics using plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int          ix;
    int          iy;
    longint      sx;
    longint      sy;
    longint      qq;
    longint      rr;
    logic [63:0] r;
    ix = x;
    iy = y;
    sx = ix;
    sy = iy;
    if (o == 2'd0) begin
      r = sx * sy;
    end else if (o == 2'd1) begin
      r = {32'd0, x} * {32'd0, y};
    end else if (y == 32'd0) begin
      r = {x, 32'hFFFFFFFF};
    end else if (o == 2'd2) begin
      qq = sx / sy;
      rr = sx % sy;
      r = {rr[31:0], qq[31:0]};
    end else begin
      r = {x % y, x / y};
    end
    return r;
  endfunction

  // Monitor: every write must match the oldest expectation at its due cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (hilo_we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", hilo_out, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("result", hilo_out, mon_e.res);
          chk("latency", 64'(cyc), 64'(mon_e.due));
          last_out = mon_e.res;
        end
      end else begin
        chk("hold", hilo_out, last_out);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit release_rst);
    int lat;
    int nst;
    lat = o[1] ? 34 : 2;
    nst = 0;
    @(posedge clk); #1;
    if (release_rst) rst = 1'b0;
    start = 1'b1; op = o; srcA = x; srcB = y;
    sb.push_back('{model(o, x, y), cyc + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (stall_req) nst++;
      if (k == 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("stall_cycles", 64'(nst), 64'(lat));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; srcA = '0; srcB = '0;
    idle_cycles(3);
    @(negedge clk);
    chk("reset_outputs", {hilo_out, busy, stall_req, hilo_we}, 67'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_op(2'd0, 32'hFFFFFFFE, 32'h00000003, 1'b0);
    run_op(2'd1, 32'hFFFFFFFE, 32'h00000003, 1'b0);
    run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd2, 32'h12345678, 32'h0, 1'b0);
    run_op(2'd3, 32'h87654321, 32'h0, 1'b0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    // DIVU aborted by flush at count 10
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(11); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hold", hilo_out, last_out);
    idle_cycles(40);
    run_op(2'd1, 32'd3, 32'd5, 1'b0);

    // Second start during DIV is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 2'd2; srcA = 32'hFFFF0000; srcB = 32'd9;
    sb.push_back('{model(2'd2, 32'hFFFF0000, 32'd9), cyc + 34});
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(5); #1;
    start = 1'b1; op = 2'd0; srcA = 32'd7; srcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(40);
    chk("single_write", 64'(sb.size()), 64'd0);

    // Start during DONE is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; srcA = 32'd6; srcB = 32'hFFFFFFFF;
    sb.push_back('{model(2'd0, 32'd6, 32'hFFFFFFFF), cyc + 2});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; srcA = 32'd11; srcB = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_start_busy", {63'd0, busy}, 64'd0);

    // start with flush in IDLE is not accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'd2; srcA = 32'd50; srcB = 32'd5;
    @(negedge clk);
    chk("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 64'(busy), 64'd0);

    // Back-to-back: second op issued in the IDLE cycle right after DONE
    run_op(2'd3, 32'hDEADBEEF, 32'd16, 1'b0);
    run_op(2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);

    // Reset mid-DIV, then a start in the cycle reset deasserts
    @(posedge clk); #1;
    start = 1'b1; op = 2'd2; srcA = 32'd12345; srcB = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(8); #1;
    rst = 1'b1;
    last_out = '0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_mid_div", {hilo_out, busy, stall_req, hilo_we}, 67'd0);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = (($urandom_range(0, 7)) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       ry = 32'h0;
        1:       ry = 32'hFFFFFFFF;
        2:       ry = 32'($urandom_range(1, 15));
        default: ry = 32'($urandom);
      endcase
      run_op(ro, rx, ry, 1'b0);
    end

    idle_cycles(4);
    chk("queue_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource in the EX stage. It accepts one MULT/MULTU/DIV/DIVU request at a time, runs a registered multiply or a 32-iteration restoring divide, and drives a stall request to the hazard unit while busy. When finished, it presents the 64-bit {HI,LO} result with a one-cycle write enable toward the HI/LO write path that feeds the register file through WB.

Parameters:
DATA_W, 32, operand width; the result is 2*DATA_W bits. Only 32 is supported and verified.

Ports:
clk  in  1  clock; all state updates on posedge clk
rst  in  1  synchronous, active-high reset
start  in  1  request pulse from EX decode; accepted only in IDLE
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcA  in  32  rs operand (dividend / multiplicand)
srcB  in  32  rt operand (divisor / multiplier)
flush  in  1  exception/pipeline flush; aborts any operation in flight
stall_req  out  1  to hazard unit; holds the pipeline while the operation runs
busy  out  1  state != IDLE
hilo_we  out  1  one-cycle write strobe for HI/LO
hilo_out  out  64  {HI[63:32], LO[31:0]}

Behaviour:
- Reset: state=IDLE; busy=0, stall_req=0, hilo_we=0, hilo_out=0; counter and operand registers cleared. rst overrides start and flush.
- States: IDLE, MUL, DIV, DONE.
- IDLE: if start && !flush, latch srcA, srcB and op. op[1]=0 goes to MUL; op[1]=1 goes to DIV with count=0. A start in any state other than IDLE is ignored.
- stall_req = (state==IDLE && start && !flush) || state==MUL || state==DIV. It is 0 in DONE, so the instruction advances in the same cycle as hilo_we.
- MUL: one cycle. Register the 64-bit product, signed for op=00 and unsigned for op=01, then go to DONE. Latency: start at cycle t gives hilo_we at t+2.
- DIV:
  - Take operand magnitudes: signed for op=10, raw for op=11.
  - Perform one restoring shift/subtract per cycle; count runs 0..31, and at count==31 go to DONE.
  - Fixups: quotient is negated if signA^signB; remainder takes the sign of the dividend.
  - Latency: start at cycle t gives hilo_we at t+34.
  - Overflow case 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0x00000000 (wrap, no trap).
- Divide by zero: detected at latch time. The block still takes the full 34 cycles; the result is forced to HI=srcA, LO=0xFFFFFFFF for both DIV and DIVU. No exception is raised.
- DONE:
  - hilo_we=1 for exactly one cycle; hilo_out holds the result.
  - Next state is IDLE.
  - hilo_out keeps its last value afterwards until the next DONE.
- Flush:
  - In MUL, DIV or DONE: next state is IDLE, hilo_we forced to 0 in that cycle, and no write occurs.
  - In IDLE, flush blocks a simultaneous start.
  - hilo_out is not updated by an aborted operation.
- Back-to-back: a start in the cycle after DONE (state IDLE) is accepted normally. A start asserted during DONE is ignored.

Test Plan:
- MULT srcA=0xFFFFFFFE (-2), srcB=0x00000003: stall_req high for 2 cycles; at t+2 hilo_we=1, hilo_out=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands gives 0x00000002_FFFFFFFA.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2: stall_req high cycles t..t+33; at t+34 hilo_we=1 with HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3). DIVU 100/7 gives HI=2, LO=14.
- DIV srcB=0, srcA=0x12345678: after 34 cycles HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU started, flush asserted at count=10: busy=0 next cycle, no hilo_we, hilo_out unchanged. A subsequent MULTU 3*5 gives hilo_out=0x00000000_0000000F.
- Second start pulse while in DIV is ignored: exactly one hilo_we occurs. A start the cycle after DONE is accepted. start together with flush in IDLE is not accepted (busy stays 0).
- rst asserted mid-DIV: on the next cycle all outputs are 0 and state is IDLE. A start in the cycle rst deasserts is accepted.
